// File: rtl/mips32_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package mips32_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data first, unless a waiting fetch has been starved.
module mem_arb_pick (
  input  logic if_elig_i,
  input  logic dm_req_i,
  input  logic starve_i,
  output logic pick_if_o,
  output logic pick_dm_o
);

  // Fetch wins when alone or when the starvation limit has been reached.
  always_comb begin
    pick_if_o = 1'b0;
    pick_dm_o = 1'b0;
    if (if_elig_i && (!dm_req_i || starve_i)) begin
      pick_if_o = 1'b1;
    end else if (dm_req_i) begin
      pick_dm_o = 1'b1;
    end else begin
      pick_if_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between the fetch and load/store ports,
// one access in flight at a time with a fixed memory read latency.
module mem_port_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              halted,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  cancel_q, cancel_d;

  logic                  if_elig_s;
  logic                  starve_s;
  logic                  arb_en_s;
  logic                  pick_if_s;
  logic                  pick_dm_s;
  arb_state_e            win_state_s;
  owner_e                win_owner_s;
  logic                  win_we_s;
  logic [ADDR_W-1:0]     win_addr_s;
  logic [DATA_W-1:0]     win_wdata_s;
  logic                  if_cancel_s;

  assign if_elig_s = if_req & ~halted;
  assign starve_s  = (streak_q == STREAK_W'(STARVE_MAX));
  assign arb_en_s  = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign if_cancel_s = flush && (owner_q == OWN_IF);

  mem_arb_pick u_pick (
    .if_elig_i (if_elig_s),
    .dm_req_i  (dm_req),
    .starve_i  (starve_s),
    .pick_if_o (pick_if_s),
    .pick_dm_o (pick_dm_s)
  );

  // Arbitration result; fetches always carry we=0 and zero write data.
  always_comb begin
    win_state_s = ST_IDLE;
    win_owner_s = OWN_NONE;
    win_we_s    = 1'b0;
    win_addr_s  = addr_q;
    win_wdata_s = wdata_q;
    if (pick_dm_s) begin
      win_state_s = ST_ISSUE;
      win_owner_s = OWN_DM;
      win_we_s    = dm_we;
      win_addr_s  = dm_addr;
      win_wdata_s = dm_wdata;
    end else if (pick_if_s) begin
      win_state_s = ST_ISSUE;
      win_owner_s = OWN_IF;
      win_we_s    = 1'b0;
      win_addr_s  = if_addr;
      win_wdata_s = {DATA_W{1'b0}};
    end else begin
      win_state_s = ST_IDLE;
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    cancel_d = cancel_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d  = win_state_s;
        owner_d  = win_owner_s;
        we_d     = win_we_s;
        addr_d   = win_addr_s;
        wdata_d  = win_wdata_s;
        cancel_d = 1'b0;
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT;
        cnt_d    = LAT_W'(MEM_LAT);
        cancel_d = cancel_q | if_cancel_s;
      end
      ST_WAIT: begin
        cancel_d = cancel_q | if_cancel_s;
        if (cnt_q == LAT_W'(1)) begin
          state_d = ST_RESP;
          rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Starvation streak: counts data grants that overtook a waiting fetch.
  always_comb begin
    if (!if_elig_s) begin
      streak_d = {STREAK_W{1'b0}};
    end else if (arb_en_s && pick_if_s) begin
      streak_d = {STREAK_W{1'b0}};
    end else if (arb_en_s && pick_dm_s && !starve_s) begin
      streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      cnt_q    <= {LAT_W{1'b0}};
      streak_q <= {STREAK_W{1'b0}};
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      cancel_q <= cancel_d;
    end
  end

  // A flush in RESP must kill the response in that same cycle.
  assign busy      = (state_q != ST_IDLE);
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en && (owner_q == OWN_DM) && we_q;
  assign mem_addr  = mem_en ? addr_q : {ADDR_W{1'b0}};
  assign mem_wdata = mem_we ? wdata_q : {DATA_W{1'b0}};
  assign if_gnt    = mem_en && (owner_q == OWN_IF);
  assign dm_gnt    = mem_en && (owner_q == OWN_DM);
  assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF) && !cancel_q && !flush;
  assign if_rdata  = ((state_q == ST_RESP) && (owner_q == OWN_IF)) ? rdata_q : {DATA_W{1'b0}};
  assign dm_rvalid = (state_q == ST_RESP) && (owner_q == OWN_DM);
  assign dm_rdata  = (dm_rvalid && !we_q) ? rdata_q : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// responses with their cycle numbers, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          if_req, flush, halted, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .flush(flush), .halted(halted),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: read data appears two cycles after the mem_en cycle.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] p1, p2;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    mem[10'h005] <= 32'h2001000A;
    mem[10'h010] <= 32'h12345678;
    mem[10'h011] <= 32'hCAFE0011;
    mem[10'h020] <= 32'hA5A50020;
    mem[10'h021] <= 32'hA5A50021;
    mem[10'h022] <= 32'hA5A50022;
    mem[10'h023] <= 32'hA5A50023;
    p1 <= 32'hBAD0BAD0;
    p2 <= 32'hBAD0BAD0;
  end
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      p1 <= mem[mem_addr];
    end else begin
      p1 <= 32'hBAD0BAD0;
    end
    p2 <= p1;
  end
  assign mem_rdata = p2;

  typedef struct { int cyc; logic [DW-1:0] data; } rsp_t;
  typedef struct { int cyc; logic is_if; } gnt_t;
  rsp_t if_exp_q[$];
  rsp_t dm_exp_q[$];
  gnt_t gnt_exp_q[$];
  rsp_t mon_r;
  gnt_t mon_g;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sample(input int c);
    goto_cyc(c);
    #3;
  endtask

  task automatic exp_gnt(input int c, input logic is_if);
    gnt_t g;
    g.cyc = c; g.is_if = is_if;
    gnt_exp_q.push_back(g);
  endtask

  task automatic exp_rsp(input int c, input logic is_if, input logic [DW-1:0] d);
    rsp_t r;
    r.cyc = c; r.data = d;
    if (is_if) if_exp_q.push_back(r);
    else dm_exp_q.push_back(r);
  endtask

  // Monitor: every grant and response must match the head of its queue.
  always @(negedge clock) begin
    if (if_gnt || dm_gnt) begin
      if (gnt_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_gnt: if_gnt=%b dm_gnt=%b at cycle %0d, none expected", if_gnt, dm_gnt, cyc);
      end else begin
        mon_g = gnt_exp_q.pop_front();
        check("gnt_owner_if", {31'd0, if_gnt}, {31'd0, mon_g.is_if});
        check("gnt_owner_dm", {31'd0, dm_gnt}, {31'd0, ~mon_g.is_if});
        check("gnt_cycle", 32'(cyc), 32'(mon_g.cyc));
      end
    end
    if (if_rvalid) begin
      if (if_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_if_rvalid: rdata 0x%08h at cycle %0d, none expected", if_rdata, cyc);
      end else begin
        mon_r = if_exp_q.pop_front();
        check("if_rdata", if_rdata, mon_r.data);
        check("if_rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (dm_rvalid) begin
      if (dm_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_dm_rvalid: rdata 0x%08h at cycle %0d, none expected", dm_rdata, cyc);
      end else begin
        mon_r = dm_exp_q.pop_front();
        check("dm_rdata", dm_rdata, mon_r.data);
        check("dm_rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  int c0;
  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0; halted = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    sample(2);
    check("reset_outputs", 32'({busy, mem_en, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 32'h0);
    check("reset_rdata", if_rdata | dm_rdata, 32'h0);
    reset_n = 1'b1;

    // Lone fetch
    c0 = cyc + 2;
    goto_cyc(c0);
    if_req = 1'b1; if_addr = 10'h005;
    exp_gnt(c0 + 1, 1'b1);
    exp_rsp(c0 + 4, 1'b1, 32'h2001000A);
    sample(c0);     check("lone_busy_idle", {31'd0, busy}, 32'd0);
    sample(c0 + 1); check("lone_busy_issue", {31'd0, busy}, 32'd1);
                    check("lone_mem_en", {31'd0, mem_en}, 32'd1);
    goto_cyc(c0 + 2); if_req = 1'b0;
    sample(c0 + 4); check("lone_busy_resp", {31'd0, busy}, 32'd1);
    sample(c0 + 5); check("lone_busy_done", {31'd0, busy}, 32'd0);

    // Contention: data first, fetch afterwards
    c0 = cyc + 2;
    goto_cyc(c0);
    if_req = 1'b1; if_addr = 10'h020;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    exp_gnt(c0 + 1, 1'b0); exp_rsp(c0 + 4, 1'b0, 32'h12345678);
    exp_gnt(c0 + 5, 1'b1); exp_rsp(c0 + 8, 1'b1, 32'hA5A50020);
    goto_cyc(c0 + 2); dm_req = 1'b0;
    goto_cyc(c0 + 6); if_req = 1'b0;

    // Starvation bound with both requests held
    c0 = c0 + 10;
    goto_cyc(c0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h011;
    if_req = 1'b1; if_addr = 10'h021;
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 7) begin
        exp_gnt(c0 + 1 + 4 * k, 1'b1);
        exp_rsp(c0 + 4 + 4 * k, 1'b1, 32'hA5A50021);
      end else begin
        exp_gnt(c0 + 1 + 4 * k, 1'b0);
        exp_rsp(c0 + 4 + 4 * k, 1'b0, 32'hCAFE0011);
      end
    end
    goto_cyc(c0 + 30); dm_req = 1'b0; if_req = 1'b0;

    // Store to the top address, then load it back
    c0 = c0 + 34;
    goto_cyc(c0);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'hDEADBEEF;
    exp_gnt(c0 + 1, 1'b0); exp_rsp(c0 + 4, 1'b0, 32'h0);
    exp_gnt(c0 + 5, 1'b0); exp_rsp(c0 + 8, 1'b0, 32'hDEADBEEF);
    sample(c0 + 1);
    check("store_mem_we", {31'd0, mem_we}, 32'd1);
    check("store_mem_addr", {22'd0, mem_addr}, 32'h3FF);
    check("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    goto_cyc(c0 + 2); dm_we = 1'b0; dm_wdata = 32'h0;
    sample(c0 + 5); check("load_mem_we", {31'd0, mem_we}, 32'd0);
    goto_cyc(c0 + 6); dm_req = 1'b0;

    // Flush during WAIT cancels the response, next fetch is normal
    c0 = c0 + 10;
    goto_cyc(c0);
    if_req = 1'b1; if_addr = 10'h022;
    exp_gnt(c0 + 1, 1'b1);
    goto_cyc(c0 + 2); if_req = 1'b0; flush = 1'b1;
    goto_cyc(c0 + 3); flush = 1'b0;
    sample(c0 + 4);
    check("flush_no_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("flush_busy_resp", {31'd0, busy}, 32'd1);
    sample(c0 + 5); check("flush_busy_done", {31'd0, busy}, 32'd0);
    goto_cyc(c0 + 6); if_req = 1'b1; if_addr = 10'h005;
    exp_gnt(c0 + 7, 1'b1); exp_rsp(c0 + 10, 1'b1, 32'h2001000A);
    goto_cyc(c0 + 8); if_req = 1'b0;

    // Flush in RESP with a new fetch pending: old dropped, new one kept
    c0 = c0 + 12;
    goto_cyc(c0);
    if_req = 1'b1; if_addr = 10'h023;
    exp_gnt(c0 + 1, 1'b1); exp_gnt(c0 + 5, 1'b1);
    exp_rsp(c0 + 8, 1'b1, 32'hA5A50023);
    goto_cyc(c0 + 4); flush = 1'b1;
    goto_cyc(c0 + 5); flush = 1'b0;
    goto_cyc(c0 + 6); if_req = 1'b0;

    // Reset in the middle of a load
    c0 = c0 + 10;
    goto_cyc(c0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    exp_gnt(c0 + 1, 1'b0);
    goto_cyc(c0 + 2);
    dm_req = 1'b0; reset_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({busy, mem_en, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 32'h0);
    goto_cyc(c0 + 4); reset_n = 1'b1;

    // Halted: fetch never granted, data still served
    c0 = c0 + 8;
    goto_cyc(c0);
    halted = 1'b1; if_req = 1'b1; if_addr = 10'h005;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    exp_gnt(c0 + 1, 1'b0); exp_rsp(c0 + 4, 1'b0, 32'h12345678);
    goto_cyc(c0 + 2); dm_req = 1'b0;
    sample(c0 + 8);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_no_if_gnt", {31'd0, if_gnt}, 32'd0);
    goto_cyc(c0 + 12); if_req = 1'b0; halted = 1'b0;

    goto_cyc(c0 + 16);
    check("gnt_queue_drained", 32'(gnt_exp_q.size()), 32'd0);
    check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    check("dm_queue_drained", 32'(dm_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
